// File: rtl/viterbi_batch_ctrl.sv
// rtl/viterbi_batch_ctrl.sv - batch run scheduler for the viterbi HLS core with a result FIFO
// Optional watchdog is compiled in when VITERBI_CTRL_TIMEOUT_EN is defined.
module viterbi_batch_ctrl #(
  parameter int RES_DEPTH      = 4,
  parameter int CNT_W          = 8,
  parameter int RET_W          = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             core_start,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic             core_idle,
  input  logic [RET_W-1:0] core_return,
  output logic             core_rst,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RET_W-1:0] res_data,
  output logic             busy,
  output logic             batch_done,
  output logic             err_timeout
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0]    CNT_FULL = CW'(RES_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
  logic [RET_W-1:0] r_mem [RES_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [RET_W-1:0] r_res_data, w_res_data_nxt;
  logic w_push, w_pop, w_full, w_wdog_exp, w_timeout, w_clr_err;
  logic w_batch_done_nxt, w_core_start_nxt, w_busy_nxt, w_res_valid_nxt;
  logic r_core_start, r_busy, r_batch_done, r_res_valid, r_core_rst, r_rst_pend;
  logic w_unused;

  // A done is only meaningful while a run is outstanding (WAIT, or START with a same-cycle ready).
  assign w_push       = core_done & ((r_state == S_WAIT) | ((r_state == S_START) & core_ready));
  assign w_pop        = r_res_valid & res_ready;
  assign w_full       = (r_count == CNT_FULL);
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
      r_batch_done <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_rst_pend   <= 1'b1;
      r_core_rst   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_core_start <= w_core_start_nxt;
      r_busy       <= w_busy_nxt;
      r_batch_done <= w_batch_done_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_res_data   <= w_res_data_nxt;
      r_rst_pend   <= 1'b0;
      r_core_rst   <= r_rst_pend | w_timeout;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_remaining_nxt  = r_remaining;
    w_batch_done_nxt = 1'b0;
    w_clr_err        = 1'b0;
    w_timeout        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_count == '0) begin
            w_batch_done_nxt = 1'b1;
          end else begin
            w_remaining_nxt = cmd_count;
            w_clr_err       = 1'b1;
            w_state_nxt     = w_full ? S_HOLD : S_START;
          end
        end
      end
      S_START, S_WAIT: begin
        if (w_push) begin
          w_remaining_nxt = r_remaining - RUN_ONE;
          if (r_remaining == RUN_ONE) begin
            w_batch_done_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
          end else begin
            w_state_nxt = (w_count_nxt != CNT_FULL) ? S_START : S_HOLD;
          end
        end else if (w_wdog_exp) begin
          w_timeout        = 1'b1;
          w_batch_done_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if ((r_state == S_START) && core_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (!w_full) w_state_nxt = S_START;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_core_start_nxt = (w_state_nxt == S_START);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_res_valid_nxt  = (w_count_nxt != '0);
  end

  // Head register tracks what mem[rd_ptr] will hold after this cycle's push/pop.
  always_comb begin
    w_res_data_nxt = r_res_data;
    if (w_pop && (r_count > CNT_ONE)) begin
      w_res_data_nxt = r_mem[w_rd_ptr_inc];
    end else if (w_push && ((r_count == '0) || (w_pop && (r_count == CNT_ONE)))) begin
      w_res_data_nxt = core_return;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= core_return;
  end

`ifdef VITERBI_CTRL_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_err_timeout;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wdog <= '0;
    end else if ((w_state_nxt == S_START) && ((r_state != S_START) || w_push)) begin
      r_wdog <= '0;
    end else if ((r_state == S_START) || (r_state == S_WAIT)) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)      r_err_timeout <= 1'b0;
    else if (w_clr_err) r_err_timeout <= 1'b0;
    else if (w_timeout) r_err_timeout <= 1'b1;
  end

  assign w_wdog_exp  = ((r_state == S_START) || (r_state == S_WAIT)) &&
                       (r_wdog >= 32'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err_timeout;
`else
  assign w_wdog_exp  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign w_unused = core_idle ^ w_clr_err ^ (TIMEOUT_CYCLES != 0);

  assign cmd_ready  = (r_state == S_IDLE);
  assign core_start = r_core_start;
  assign core_rst   = r_core_rst;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign busy       = r_busy;
  assign batch_done = r_batch_done;

  assert property (@(posedge ap_clk) disable iff (!ap_rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_viterbi_batch_ctrl.sv
// tb/tb_viterbi_batch_ctrl.sv - self-checking bench for viterbi_batch_ctrl
module tb_viterbi_batch_ctrl;
  localparam int CNT_W = 8;
  localparam int RET_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [CNT_W-1:0] cmd_count = '0;
  logic core_start, core_ready = 1'b0, core_done = 1'b0, core_idle = 1'b1;
  logic [RET_W-1:0] core_return = '0;
  logic core_rst, res_valid, res_ready = 1'b0;
  logic [RET_W-1:0] res_data;
  logic busy, batch_done, err_timeout;

  always #5 clk = ~clk;

  viterbi_batch_ctrl #(.RES_DEPTH(4), .CNT_W(CNT_W), .RET_W(RET_W), .TIMEOUT_CYCLES(100)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .core_start(core_start), .core_ready(core_ready),
    .core_done(core_done), .core_idle(core_idle), .core_return(core_return),
    .core_rst(core_rst), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .batch_done(batch_done), .err_timeout(err_timeout)
  );

  typedef struct {
    int count;
    int lat;
    int pct;
    int exp_runs;
    int exp_bd;
  } vec_t;

  int total = 0, bad = 0;
  int lat = 1, rdy_pct = 100;
  bit hang = 1'b0, running = 1'b0, chk_bd_timing = 1'b0, prev_hold = 1'b0;
  int cd = 0, runs = 0, pops = 0, bdones = 0, cyc = 0, last_done_cyc = -10;
  int bd_cyc = 0, core_rst_hi = 0;
  logic [RET_W-1:0] cur_ret = '0, prev_data = '0;
  logic [RET_W-1:0] fixed_q[$];
  logic [RET_W-1:0] sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor, result consumer and behavioural core, all at the falling edge in a fixed order.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (batch_done) begin
        bdones++;
        bd_cyc = cyc;
        if (chk_bd_timing) check("batch_done_after_last_done", cyc - last_done_cyc, 1);
      end
      if (core_rst) core_rst_hi++;
      if (prev_hold && res_valid) check("res_data_stable", res_data, prev_data);
      res_ready = ($urandom_range(99) < rdy_pct);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) check("extra_result", 1, 0);
        else check("res_data", res_data, sb.pop_front());
        pops++;
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;

      core_ready = 1'b0;
      core_done  = 1'b0;
      if (!rst_n || core_rst) begin
        running = 1'b0;
      end else if (running) begin
        if (!hang) begin
          cd--;
          if (cd <= 0) begin
            core_done = 1'b1;
            core_return = cur_ret;
            sb.push_back(cur_ret);
            last_done_cyc = cyc;
            running = 1'b0;
          end
        end
      end else if (core_start) begin
        runs++;
        core_ready = 1'b1;
        cur_ret = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom;
        if (lat == 0 && !hang) begin
          core_done = 1'b1;
          core_return = cur_ret;
          sb.push_back(cur_ret);
          last_done_cyc = cyc;
        end else begin
          running = 1'b1;
          cd = lat;
        end
      end
      core_idle = !running;
    end
  end

  task automatic send_cmd(input int n);
    int t = 0;
    cmd_count = CNT_W'(n);
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("cmd_accept_wait", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bd(input string name, input int b0);
    int t = 0;
    while (bdones == b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check({name, "_batch_done_wait"}, 0, 1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((res_valid || sb.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check({name, "_drain_wait"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic run_batch(input string name, input int n, input int exp_runs, input int exp_bd);
    int r0, p0, b0;
    r0 = runs;
    p0 = pops;
    b0 = bdones;
    chk_bd_timing = (n != 0);
    send_cmd(n);
    if (n != 0) check({name, "_busy_after_accept"}, busy, 1);
    wait_bd(name, b0);
    drain(name);
    check({name, "_runs"}, runs - r0, exp_runs);
    check({name, "_batch_done_pulses"}, bdones - b0, exp_bd);
    check({name, "_results"}, pops - p0, exp_runs);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int r0, p0, b0, c0, t, sum;
    tbl[0] = '{count: 0, lat: 1, pct: 100, exp_runs: 0, exp_bd: 1};
    tbl[1] = '{count: 5, lat: 0, pct: 100, exp_runs: 5, exp_bd: 1};
    tbl[2] = '{count: 4, lat: 0, pct: 35,  exp_runs: 4, exp_bd: 1};
    tbl[3] = '{count: 6, lat: 2, pct: 60,  exp_runs: 6, exp_bd: 1};
    tbl[4] = '{count: 9, lat: 3, pct: 25,  exp_runs: 9, exp_bd: 1};
    tbl[5] = '{count: 1, lat: 1, pct: 100, exp_runs: 1, exp_bd: 1};

    repeat (3) @(negedge clk);
    check("rst_core_rst", core_rst, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_core_start", core_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("core_rst_first_cycle", core_rst, 1);
    @(negedge clk);
    check("core_rst_second_cycle", core_rst, 0);

    // Batch of 3 with fixed returns, start visible one cycle after accept
    lat = 1;
    rdy_pct = 100;
    fixed_q = '{32'h11, 32'h22, 32'h33};
    r0 = runs; p0 = pops; b0 = bdones;
    chk_bd_timing = 1'b1;
    send_cmd(3);
    check("b3_core_start_after_accept", core_start, 1);
    wait_bd("b3", b0);
    drain("b3");
    check("b3_runs", runs - r0, 3);
    check("b3_results", pops - p0, 3);
    check("b3_batch_done_pulses", bdones - b0, 1);

    for (int i = 0; i < 6; i++) begin
      lat = tbl[i].lat;
      rdy_pct = tbl[i].pct;
      run_batch($sformatf("vec%0d", i), tbl[i].count, tbl[i].exp_runs, tbl[i].exp_bd);
    end

    // Full FIFO throttles starts
    lat = 1;
    rdy_pct = 0;
    r0 = runs; p0 = pops; b0 = bdones;
    send_cmd(6);
    repeat (40) @(negedge clk);
    check("hold_runs", runs - r0, 4);
    check("hold_res_valid", res_valid, 1);
    check("hold_busy", busy, 1);
    check("hold_core_start", core_start, 0);
    check("hold_cmd_ready", cmd_ready, 0);
    rdy_pct = 100;
    wait_bd("hold", b0);
    drain("hold");
    check("hold_runs_total", runs - r0, 6);
    check("hold_results_total", pops - p0, 6);

    // Back-to-back random batches without draining in between
    r0 = runs; p0 = pops; sum = 0;
    for (int i = 0; i < 6; i++) begin
      int n, rr, bb;
      n = $urandom_range(12, 1);
      lat = $urandom_range(3, 0);
      rdy_pct = $urandom_range(100, 10);
      rr = runs; bb = bdones;
      sum += n;
      send_cmd(n);
      wait_bd("rand", bb);
      @(negedge clk);
      check($sformatf("rand%0d_runs", i), runs - rr, n);
      check($sformatf("rand%0d_batch_done_pulses", i), bdones - bb, 1);
    end
    rdy_pct = 100;
    drain("rand");
    check("rand_results_total", pops - p0, sum);
    check("rand_runs_total", runs - r0, sum);

    // Reset in WAIT with 2 results buffered
    lat = 6;
    rdy_pct = 0;
    send_cmd(5);
    t = 0;
    while (!(sb.size() == 2 && running && !core_start && res_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("rst_mid_setup_wait", 0, 1);
    rst_n = 1'b0;
    chk_bd_timing = 1'b0;
    @(negedge clk);
    sb.delete();
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_core_rst", core_rst, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_core_rst_after_release", core_rst, 1);
    @(negedge clk);
    check("mid_rst_core_rst_drop", core_rst, 0);
    check("mid_rst_fifo_empty", res_valid, 0);
    lat = 2;
    rdy_pct = 100;
    run_batch("after_rst", 1, 1, 1);

`ifdef VITERBI_CTRL_TIMEOUT_EN
    hang = 1'b1;
    chk_bd_timing = 1'b0;
    b0 = bdones;
    c0 = cyc;
    t = core_rst_hi;
    send_cmd(3);
    wait_bd("tmo", b0);
    repeat (2) @(negedge clk);
    check("tmo_latency_ok", (bd_cyc - c0) <= 102, 1);
    check("tmo_core_rst_pulse", core_rst_hi - t, 1);
    check("tmo_err_timeout", err_timeout, 1);
    check("tmo_no_results", res_valid, 0);
    hang = 1'b0;
    lat = 1;
    b0 = bdones;
    chk_bd_timing = 1'b1;
    send_cmd(1);
    check("tmo_err_cleared", err_timeout, 0);
    wait_bd("tmo_next", b0);
    drain("tmo_next");
`else
    check("no_wdog_err_timeout", err_timeout, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
